multi_ns_iterator_gen: RTL and testbench

Parametrised multi-namespace iterator and nested-loop address generator for the Genesys SIMD front-end. It holds a per-namespace base/stride table and a programmable loop nest of up to NUM_MAX_LOOPS levels. On start it fetches each namespace's base and per-loop strides, then streams one packed address vector per accepted beat under ready/valid backpressure. It replaces the fixed six-namespace iterator bank; namespace count, loop depth and widths are generic.

---
 rtl/iter_gen_pkg.sv | 32 +++
 rtl/multi_ns_iterator_gen_if.sv | 14 +
 rtl/iter_table.sv | 31 +++
 rtl/multi_ns_iterator_gen.sv | 187 ++++++++++++++++++
 tb/tb_multi_ns_iterator_gen.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iter_gen_pkg.sv
// Shared types, default widths and lane pack/unpack helpers for the
// multi-namespace iterator generator.
package iter_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } iter_state_t;

  localparam int DEF_NUM_NS        = 6;
  localparam int DEF_IDX_W         = 5;
  localparam int DEF_ADDR_W        = 32;
  localparam int DEF_NUM_MAX_LOOPS = 8;
  localparam int DEF_LOOP_ID_W     = 3;
  localparam int DEF_NUM_ITER_W    = 16;

  function automatic logic [DEF_ADDR_W-1:0] addr_lane(
    input logic [DEF_NUM_NS*DEF_ADDR_W-1:0] vec,
    input int                               n
  );
    return vec[n*DEF_ADDR_W +: DEF_ADDR_W];
  endfunction

  function automatic logic [DEF_NUM_NS*DEF_IDX_W-1:0] idx_fill(
    input logic [DEF_IDX_W-1:0] idx
  );
    return {DEF_NUM_NS{idx}};
  endfunction

endpackage

// File: rtl/multi_ns_iterator_gen_if.sv
// Address-vector stream: master drives one packed vector per beat,
// slave applies backpressure with addr_ready.
interface multi_ns_iterator_gen_if #(
  parameter int NUM_NS = iter_gen_pkg::DEF_NUM_NS,
  parameter int ADDR_W = iter_gen_pkg::DEF_ADDR_W
);
  logic                     addr_valid;
  logic                     addr_ready;
  logic                     addr_last;
  logic [NUM_NS*ADDR_W-1:0] addr_out;

  modport master (output addr_valid, output addr_last, output addr_out, input addr_ready);
  modport slave  (input addr_valid, input addr_last, input addr_out, output addr_ready);
endinterface

// File: rtl/iter_table.sv
// Per-namespace base/stride table: one write port, two registered read ports.
// Read latency 1 cycle, read-first on address collision; never stalls.
module iter_table #(
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] wr_stride,
  input  logic [IDX_W-1:0]  rd_base_idx,
  input  logic [IDX_W-1:0]  rd_stride_idx,
  output logic [ADDR_W-1:0] rd_base,
  output logic [ADDR_W-1:0] rd_stride
);

  logic [ADDR_W-1:0] base_mem   [2**IDX_W];
  logic [ADDR_W-1:0] stride_mem [2**IDX_W];

  // Reads sample the array before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      base_mem[wr_idx]   <= wr_base;
      stride_mem[wr_idx] <= wr_stride;
    end
    rd_base   <= base_mem[rd_base_idx];
    rd_stride <= stride_mem[rd_stride_idx];
  end

endmodule

// File: rtl/multi_ns_iterator_gen.sv
// Nested-loop multi-namespace address generator; first beat L+3 cycles after start,
// one beat per cycle under addr_ready backpressure. Optional ITER_STALL_CNT_EN stall counter.
module multi_ns_iterator_gen
  import iter_gen_pkg::*;
#(
  parameter int NUM_NS        = DEF_NUM_NS,
  parameter int IDX_W         = DEF_IDX_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int NUM_MAX_LOOPS = DEF_NUM_MAX_LOOPS,
  parameter int LOOP_ID_W     = DEF_LOOP_ID_W,
  parameter int NUM_ITER_W    = DEF_NUM_ITER_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tbl_wr_en,
  input  logic [$clog2(NUM_NS)-1:0]  tbl_wr_ns,
  input  logic [IDX_W-1:0]           tbl_wr_idx,
  input  logic [ADDR_W-1:0]          tbl_wr_base,
  input  logic [ADDR_W-1:0]          tbl_wr_stride,
  input  logic                       loop_cfg_en,
  input  logic [LOOP_ID_W-1:0]       loop_cfg_id,
  input  logic [NUM_ITER_W-1:0]      loop_cfg_num_iter,
  input  logic [NUM_NS*IDX_W-1:0]    loop_cfg_idx,
  input  logic [NUM_NS*IDX_W-1:0]    base_idx,
  input  logic [LOOP_ID_W-1:0]       num_loops_m1,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  multi_ns_iterator_gen_if.master    addr_if,
  output logic [31:0]                stall_cnt
);

  localparam int NS_W = $clog2(NUM_NS);
  localparam int LC_W = LOOP_ID_W + 1;

  iter_state_t state, state_nxt;

  logic [LC_W-1:0]         load_cnt;
  logic [LOOP_ID_W-1:0]    num_loops_q;
  logic [NUM_NS*IDX_W-1:0] base_idx_q;
  logic [NUM_ITER_W-1:0]   cfg_num_iter [NUM_MAX_LOOPS];
  logic [NUM_NS*IDX_W-1:0] cfg_idx      [NUM_MAX_LOOPS];
  logic [NUM_ITER_W-1:0]   cnt          [NUM_MAX_LOOPS];
  logic [ADDR_W-1:0]       stride_q     [NUM_MAX_LOOPS][NUM_NS];
  logic [ADDR_W-1:0]       acc          [NUM_MAX_LOOPS][NUM_NS];
  logic [ADDR_W-1:0]       rd_base      [NUM_NS];
  logic [ADDR_W-1:0]       rd_stride    [NUM_NS];
  logic [ADDR_W-1:0]       inc_acc      [NUM_NS];
  logic [NUM_NS*IDX_W-1:0] stride_rd_idx;
  logic [NUM_NS*ADDR_W-1:0] addr_vec;

  logic                     start_acc;
  logic                     fire;
  logic                     last;
  logic                     addr_valid;
  logic [NUM_MAX_LOOPS-1:0] sat;
  logic [LOOP_ID_W-1:0]     inc_lvl;

  assign start_acc     = start && (state == IDLE);
  assign fire          = (state == RUN) && addr_if.addr_ready;
  assign stride_rd_idx = cfg_idx[load_cnt[LOOP_ID_W-1:0]];

  for (genvar n = 0; n < NUM_NS; n++) begin : g_tbl
    iter_table #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_tbl (
      .clk          (clk),
      .wr_en        (tbl_wr_en && (tbl_wr_ns == NS_W'(n))),
      .wr_idx       (tbl_wr_idx),
      .wr_base      (tbl_wr_base),
      .wr_stride    (tbl_wr_stride),
      .rd_base_idx  (base_idx_q[n*IDX_W +: IDX_W]),
      .rd_stride_idx(stride_rd_idx[n*IDX_W +: IDX_W]),
      .rd_base      (rd_base[n]),
      .rd_stride    (rd_stride[n])
    );
  end

  // Levels above L count as saturated so the increment never reaches them.
  always_comb begin
    sat     = '0;
    inc_lvl = '0;
    for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
      sat[l] = (LOOP_ID_W'(l) > num_loops_q) ||
               (({1'b0, cnt[l]} + (NUM_ITER_W+1)'(1)) >= {1'b0, cfg_num_iter[l]});
    end
    for (int l = NUM_MAX_LOOPS - 1; l >= 0; l--) begin
      if (!sat[l]) inc_lvl = LOOP_ID_W'(l);
    end
    last = &sat;
    for (int n = 0; n < NUM_NS; n++) begin
      inc_acc[n] = acc[inc_lvl][n] + stride_q[inc_lvl][n];
      addr_vec[n*ADDR_W +: ADDR_W] = acc[0][n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    addr_valid = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        busy = 1'b1;
        if (load_cnt == LC_W'(num_loops_q) + LC_W'(1)) state_nxt = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        addr_valid = 1'b1;
        if (addr_if.addr_ready && last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign addr_if.addr_valid = addr_valid;
  assign addr_if.addr_last  = addr_valid && last;
  assign addr_if.addr_out   = addr_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt    <= '0;
      num_loops_q <= '0;
      base_idx_q  <= '0;
      for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
        cfg_num_iter[l] <= '0;
        cfg_idx[l]      <= '0;
      end
    end else begin
      if ((state == IDLE) && loop_cfg_en) begin
        cfg_num_iter[loop_cfg_id] <= loop_cfg_num_iter;
        cfg_idx[loop_cfg_id]      <= loop_cfg_idx;
      end
      if (start_acc) begin
        num_loops_q <= num_loops_m1;
        base_idx_q  <= base_idx;
        load_cnt    <= '0;
      end else if (state == LOAD) begin
        load_cnt <= load_cnt + LC_W'(1);
      end
    end
  end

  // Read data trails the issued address by one LOAD cycle.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      if (load_cnt != '0) begin
        for (int n = 0; n < NUM_NS; n++)
          stride_q[LOOP_ID_W'(load_cnt - LC_W'(1))][n] <= rd_stride[n];
      end
      if (load_cnt == LC_W'(1)) begin
        for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
          cnt[l] <= '0;
          for (int n = 0; n < NUM_NS; n++) acc[l][n] <= rd_base[n];
        end
      end
    end else if (fire && !last) begin
      for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
        if (LOOP_ID_W'(l) == inc_lvl) begin
          cnt[l] <= cnt[l] + NUM_ITER_W'(1);
          for (int n = 0; n < NUM_NS; n++) acc[l][n] <= inc_acc[n];
        end else if (LOOP_ID_W'(l) < inc_lvl) begin
          cnt[l] <= '0;
          for (int n = 0; n < NUM_NS; n++) acc[l][n] <= inc_acc[n];
        end
      end
    end
  end

`ifdef ITER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc)                          stall_cnt <= '0;
    else if ((state == RUN) && !addr_if.addr_ready)  stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_ns_iterator_gen.sv
// Directed bench for multi_ns_iterator_gen: hand-computed address sequences,
// latency, last/done timing, backpressure hold, wrap, lane independence, reset mid-run.
`timescale 1ns/1ps
module tb_multi_ns_iterator_gen;
  import iter_gen_pkg::*;

  localparam int NUM_NS = DEF_NUM_NS;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int VEC_W  = NUM_NS * ADDR_W;
  typedef logic [VEC_W-1:0] val_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    tbl_wr_en;
  logic [2:0]              tbl_wr_ns;
  logic [4:0]              tbl_wr_idx;
  logic [31:0]             tbl_wr_base;
  logic [31:0]             tbl_wr_stride;
  logic                    loop_cfg_en;
  logic [2:0]              loop_cfg_id;
  logic [15:0]             loop_cfg_num_iter;
  logic [NUM_NS*5-1:0]     loop_cfg_idx;
  logic [NUM_NS*5-1:0]     base_idx;
  logic [2:0]              num_loops_m1;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [31:0]             stall_cnt;

  int total = 0;
  int bad   = 0;
  val_t        got_addr[$];
  logic        got_last[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  multi_ns_iterator_gen_if #(.NUM_NS(NUM_NS), .ADDR_W(ADDR_W)) aif();

  multi_ns_iterator_gen dut (
    .clk              (clk),
    .reset            (reset),
    .tbl_wr_en        (tbl_wr_en),
    .tbl_wr_ns        (tbl_wr_ns),
    .tbl_wr_idx       (tbl_wr_idx),
    .tbl_wr_base      (tbl_wr_base),
    .tbl_wr_stride    (tbl_wr_stride),
    .loop_cfg_en      (loop_cfg_en),
    .loop_cfg_id      (loop_cfg_id),
    .loop_cfg_num_iter(loop_cfg_num_iter),
    .loop_cfg_idx     (loop_cfg_idx),
    .base_idx         (base_idx),
    .num_loops_m1     (num_loops_m1),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .addr_if          (aif),
    .stall_cnt        (stall_cnt)
  );

  task automatic chk(input string tag, input val_t got, input val_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input int ns, input int idx, input logic [31:0] b, input logic [31:0] s);
    tbl_wr_en = 1'b1; tbl_wr_ns = 3'(ns); tbl_wr_idx = 5'(idx);
    tbl_wr_base = b; tbl_wr_stride = s;
    step();
    tbl_wr_en = 1'b0;
  endtask

  task automatic loop_cfg(input int id, input int n_iter, input int idx);
    loop_cfg_en = 1'b1; loop_cfg_id = 3'(id);
    loop_cfg_num_iter = 16'(n_iter); loop_cfg_idx = idx_fill(5'(idx));
    step();
    loop_cfg_en = 1'b0;
  endtask

  // Returns in the first cycle addr_valid is seen.
  task automatic launch(input int idx, input int l, input string tag);
    int lat;
    base_idx = idx_fill(5'(idx)); num_loops_m1 = 3'(l); start = 1'b1;
    step();
    start = 1'b0; lat = 1;
    chk({tag, "_busy"}, val_t'(busy), val_t'(1));
    while (!aif.addr_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, val_t'(lat), val_t'(l + 3));
  endtask

  task automatic collect(input int nexp, input logic [31:0] rmask, input bit end_chk, input string tag);
    int   cyc   = 0;
    int   beats = 0;
    bit   held_vld = 1'b0;
    val_t held = '0;
    got_addr.delete(); got_last.delete();
    while (beats < nexp && cyc < 200) begin
      aif.addr_ready = (cyc < 32) ? rmask[cyc] : 1'b1;
      if (aif.addr_valid) begin
        if (held_vld) chk({tag, "_hold"}, aif.addr_out, held);
        if (aif.addr_ready) begin
          got_addr.push_back(aif.addr_out);
          got_last.push_back(aif.addr_last);
          beats++;
          held_vld = 1'b0;
        end else begin
          held = aif.addr_out;
          held_vld = 1'b1;
        end
      end
      step();
      cyc++;
    end
    aif.addr_ready = 1'b0;
    chk({tag, "_beats"}, val_t'(beats), val_t'(nexp));
    if (end_chk) begin
      chk({tag, "_done"}, val_t'(done), val_t'(1));
      chk({tag, "_busy_end"}, val_t'(busy), val_t'(0));
      chk({tag, "_vld_end"}, val_t'(aif.addr_valid), val_t'(0));
      step();
      chk({tag, "_done_pulse"}, val_t'(done), val_t'(0));
      chk({tag, "_idle"}, val_t'(busy), val_t'(0));
    end
  endtask

  task automatic chk_lane0(input string tag);
    chk({tag, "_n"}, val_t'(got_addr.size()), val_t'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_addr.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), val_t'(addr_lane(got_addr[i], 0)), val_t'(exp_q[i]));
      chk($sformatf("%s_l%0d", tag, i), val_t'(got_last[i]), val_t'(i == exp_q.size() - 1));
    end
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; tbl_wr_en = 1'b0; tbl_wr_ns = '0; tbl_wr_idx = '0;
    tbl_wr_base = '0; tbl_wr_stride = '0; loop_cfg_en = 1'b0; loop_cfg_id = '0;
    loop_cfg_num_iter = '0; loop_cfg_idx = '0; base_idx = '0; num_loops_m1 = '0;
    start = 1'b0; aif.addr_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_busy", val_t'(busy), val_t'(0));
    chk("rst_done", val_t'(done), val_t'(0));
    chk("rst_vld",  val_t'(aif.addr_valid), val_t'(0));
    chk("rst_last", val_t'(aif.addr_last), val_t'(0));
    chk("rst_stall", val_t'(stall_cnt), val_t'(0));

    for (int n = 0; n < NUM_NS; n++) begin
      tbl_write(n, 0, 32'h0,         32'h0);
      tbl_write(n, 1, 32'h100,       32'h4);
      tbl_write(n, 2, 32'h0,         32'h1);
      tbl_write(n, 3, 32'h0,         32'h10);
      tbl_write(n, 4, 32'hFFFF_FFFC, 32'h4);
      tbl_write(n, 5, 32'h1000,      32'(n + 1));
      tbl_write(n, 6, 32'h5555,      32'h100);
    end

    // single loop; a config write and a start during RUN must be ignored
    loop_cfg(0, 3, 1);
    loop_cfg(2, 7, 1);
    launch(1, 0, "t1");
    loop_cfg_en = 1'b1; loop_cfg_id = 3'd0; loop_cfg_num_iter = 16'd9;
    loop_cfg_idx = idx_fill(5'd2); start = 1'b1;
    step();
    loop_cfg_en = 1'b0; start = 1'b0;
    collect(3, '1, 1'b1, "t1");
    exp_q = '{32'h100, 32'h104, 32'h108};
    chk_lane0("t1");

    // two levels
    loop_cfg(0, 2, 2);
    loop_cfg(1, 3, 3);
    launch(2, 1, "t2");
    collect(6, '1, 1'b1, "t2");
    exp_q = '{32'h0, 32'h1, 32'h10, 32'h11, 32'h20, 32'h21};
    chk_lane0("t2");

    // backpressure 1,0,0,1
    loop_cfg(0, 3, 1);
    launch(1, 0, "t3");
    collect(3, 32'hFFFF_FFF9, 1'b1, "t3");
    exp_q = '{32'h100, 32'h104, 32'h108};
    chk_lane0("t3");
`ifdef ITER_STALL_CNT_EN
    chk("t3_stall", val_t'(stall_cnt), val_t'(2));
`else
    chk("t3_stall", val_t'(stall_cnt), val_t'(0));
`endif

    // address wrap
    loop_cfg(0, 2, 4);
    launch(4, 0, "t4");
    collect(2, '1, 1'b1, "t4");
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    chk_lane0("t4");

    // lane independence; outer level with num_iter 0 runs once
    loop_cfg(0, 3, 5);
    loop_cfg(1, 0, 6);
    launch(5, 1, "t5");
    collect(3, '1, 1'b1, "t5");
    chk("t5_n", val_t'(got_addr.size()), val_t'(3));
    for (int k = 0; k < 3 && k < got_addr.size(); k++) begin
      for (int n = 0; n < NUM_NS; n++)
        chk($sformatf("t5_b%0d_n%0d", k, n), val_t'(addr_lane(got_addr[k], n)),
            val_t'(32'h1000 + 32'(k * (n + 1))));
      chk($sformatf("t5_l%0d", k), val_t'(got_last[k]), val_t'(k == 2));
    end

    // reset after two beats
    loop_cfg(0, 3, 1);
    launch(1, 0, "t6");
    collect(2, '1, 1'b0, "t6");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_vld_rst", val_t'(aif.addr_valid), val_t'(0));
    chk("t6_busy_rst", val_t'(busy), val_t'(0));
    done_seen = int'(done);
    repeat (3) begin
      step();
      done_seen = done_seen | int'(done);
    end
    chk("t6_no_done", val_t'(done_seen), val_t'(0));

    // loop config was cleared: level 0 num_iter 0 gives one beat
    launch(1, 0, "t6r");
    collect(1, '1, 1'b1, "t6r");
    exp_q = '{32'h100};
    chk_lane0("t6r");

    loop_cfg(0, 3, 1);
    launch(1, 0, "t6b");
    collect(3, '1, 1'b1, "t6b");
    exp_q = '{32'h100, 32'h104, 32'h108};
    chk_lane0("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
